// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and lock-state encoding.
// Used by the monitor and by any display generator driving it.
package vga_timing_pkg;

    localparam int H_TOTAL      = 800;
    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_LEN   = 96;
    localparam int H_VISIBLE    = 640;

    localparam int V_TOTAL      = 525;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_LEN   = 2;
    localparam int V_VISIBLE    = 480;

    // Width of coordinate counters and period meters.
    localparam int CW = 11;

    // Consecutive clean frames needed before declaring lock.
    localparam int GOOD_FRAMES = 2;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } lock_state_t;

endpackage

// File: rtl/vga_period_meter.sv
// Measures the spacing between edges in units of enabled cycles.
// Ports: clk, reset (async low), edge_i, cnt_en_i, expected_i, err_o.
module vga_period_meter
    import vga_timing_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          edge_i,
    input  logic          cnt_en_i,
    input  logic [CW-1:0] expected_i,
    output logic          err_o
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] cnt_q, cnt_d, inc;
    logic          first_q, first_d;
    logic          err_q, err_d;

    // inc includes the current cycle, so a coincident enable on the
    // closing edge is counted in the period that edge terminates.
    always_comb begin
        inc = cnt_q;
        if (cnt_en_i && (cnt_q != CNT_MAX)) begin
            inc = cnt_q + 1'b1;
        end
        cnt_d   = inc;
        first_d = first_q;
        err_d   = 1'b0;
        if (edge_i) begin
            cnt_d   = '0;
            first_d = 1'b0;
            err_d   = !first_q && (inc != expected_i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            first_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/vga_rx_monitor.sv
// Recovers pixel coordinates from a VGA stream, tracks timing lock and
// captures the colour at a probe coordinate.
// Ports: clk, reset (async low), hsync/vsync (active low), vga_r/g/b,
//   probe_x/y in; hpos/vpos, pix_rgb, pos_valid, locked, probe_rgb,
//   probe_valid, line_err, frame_err, frame_done out.
module vga_rx_monitor
    import vga_timing_pkg::*;
#(
    parameter int HTotal     = H_TOTAL,
    parameter int HSyncStart = H_SYNC_START,
    parameter int HVisible   = H_VISIBLE,
    parameter int VTotal     = V_TOTAL,
    parameter int VSyncStart = V_SYNC_START,
    parameter int VVisible   = V_VISIBLE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  vga_r,
    input  logic [3:0]  vga_g,
    input  logic [3:0]  vga_b,
    input  logic [10:0] probe_x,
    input  logic [10:0] probe_y,
    output logic [10:0] hpos,
    output logic [10:0] vpos,
    output logic [11:0] pix_rgb,
    output logic        pos_valid,
    output logic        locked,
    output logic [11:0] probe_rgb,
    output logic        probe_valid,
    output logic        line_err,
    output logic        frame_err,
    output logic        frame_done
);

    logic          hs_prev_q, vs_prev_q;
    logic          hs_fall, vs_fall, hwrap;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic [11:0]   pix_q;
    logic          vs_fall_q;
    lock_state_t   state_q, state_d;
    logic [1:0]    good_q, good_d;
    logic          locked_q;
    logic          frame_done_q;
    logic [11:0]   probe_rgb_q;
    logic          probe_valid_q;
    logic          probe_hit;
    logic          line_err_w, frame_err_w, err_any;

    assign hs_fall = hs_prev_q & ~hsync;
    assign vs_fall = vs_prev_q & ~vsync;
    assign hwrap   = !hs_fall && (hcnt_q == CW'(HTotal - 1));

    // Counters track the coordinate of the pixel being registered;
    // sync falls re-anchor them and win over free running.
    always_comb begin
        hcnt_d = hcnt_q + 1'b1;
        if (hwrap) hcnt_d = '0;
        if (hs_fall) hcnt_d = CW'(HSyncStart);
        vcnt_d = vcnt_q;
        if (hwrap) begin
            vcnt_d = (vcnt_q == CW'(VTotal - 1)) ? '0 : vcnt_q + 1'b1;
        end
        if (vs_fall) vcnt_d = CW'(VSyncStart);
    end

    vga_period_meter u_line_meter (
        .clk        (clk),
        .reset      (reset),
        .edge_i     (hs_fall),
        .cnt_en_i   (1'b1),
        .expected_i (CW'(HTotal)),
        .err_o      (line_err_w)
    );

    vga_period_meter u_frame_meter (
        .clk        (clk),
        .reset      (reset),
        .edge_i     (vs_fall),
        .cnt_en_i   (hs_fall),
        .expected_i (CW'(VTotal)),
        .err_o      (frame_err_w)
    );

    assign err_any = line_err_w | frame_err_w;

    // Frame boundaries are acted on one cycle late so that the frame
    // error verdict for the closing frame is already available.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        unique case (state_q)
            SEARCH: begin
                if (vs_fall_q) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            end
            ACQUIRE: begin
                if (err_any) begin
                    state_d = SEARCH;
                    good_d  = '0;
                end else if (vs_fall_q) begin
                    good_d = good_q + 2'd1;
                    if (good_q == 2'(GOOD_FRAMES - 1)) state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (err_any) begin
                    state_d = SEARCH;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = SEARCH;
                good_d  = '0;
            end
        endcase
    end

    assign pos_valid = locked_q
                    && (hcnt_q < CW'(HVisible))
                    && (vcnt_q < CW'(VVisible));

    assign probe_hit = pos_valid
                    && (hcnt_q == probe_x)
                    && (vcnt_q == probe_y);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            pix_q         <= '0;
            vs_fall_q     <= 1'b0;
            state_q       <= SEARCH;
            good_q        <= '0;
            locked_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            probe_rgb_q   <= '0;
            probe_valid_q <= 1'b0;
        end else begin
            hs_prev_q     <= hsync;
            vs_prev_q     <= vsync;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            pix_q         <= {vga_r, vga_g, vga_b};
            vs_fall_q     <= vs_fall;
            state_q       <= state_d;
            good_q        <= good_d;
            locked_q      <= (state_d == LOCKED);
            frame_done_q  <= vs_fall & locked_q;
            probe_valid_q <= probe_hit;
            if (probe_hit) probe_rgb_q <= pix_q;
        end
    end

    assign hpos        = hcnt_q;
    assign vpos        = vcnt_q;
    assign pix_rgb     = pix_q;
    assign locked      = locked_q;
    assign probe_rgb   = probe_rgb_q;
    assign probe_valid = probe_valid_q;
    assign line_err    = line_err_w;
    assign frame_err   = frame_err_w;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor using a scaled-down raster
// (40x20 total, 32x12 visible) so whole frames stay short.
module tb_vga_rx_monitor;

    localparam int HT  = 40;
    localparam int HS  = 34;
    localparam int HSL = 4;
    localparam int HV  = 32;
    localparam int VT  = 20;
    localparam int VS  = 15;
    localparam int VSL = 2;
    localparam int VV  = 12;
    localparam int PX  = 10;
    localparam int PY  = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsync, vsync;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic [10:0] probe_x, probe_y;
    logic [10:0] hpos, vpos;
    logic [11:0] pix_rgb, probe_rgb;
    logic        pos_valid, locked, probe_valid;
    logic        line_err, frame_err, frame_done;

    int tests = 0;
    int fails = 0;
    int gx = 0, gy = 0, lx = 0, ly = 0;
    logic [11:0] lrgb;
    int mode = 0;
    int short_y = -1;
    bit short_frame = 1'b0;
    int le_cnt = 0, fe_cnt = 0, pv_cnt = 0, fd_cnt = 0;
    int le0, fe0, pv0, fd0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (line_err) le_cnt++;
        if (frame_err) fe_cnt++;
        if (probe_valid) pv_cnt++;
        if (frame_done) fd_cnt++;
    end

    vga_rx_monitor #(
        .HTotal     (HT),
        .HSyncStart (HS),
        .HVisible   (HV),
        .VTotal     (VT),
        .VSyncStart (VS),
        .VVisible   (VV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hsync       (hsync),
        .vsync       (vsync),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .probe_x     (probe_x),
        .probe_y     (probe_y),
        .hpos        (hpos),
        .vpos        (vpos),
        .pix_rgb     (pix_rgb),
        .pos_valid   (pos_valid),
        .locked      (locked),
        .probe_rgb   (probe_rgb),
        .probe_valid (probe_valid),
        .line_err    (line_err),
        .frame_err   (frame_err),
        .frame_done  (frame_done)
    );

    function automatic logic [11:0] rgb_at(int x, int y);
        logic [31:0] xv, yv;
        xv = x;
        yv = y;
        if (mode == 1) return {xv[3:0], yv[3:0], 4'hA};
        if (x == PX && y == PY) return 12'hFFF;
        return 12'h137;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive the current raster pixel, clock it in, then advance.
    task automatic step();
        lrgb = rgb_at(gx, gy);
        {vga_r, vga_g, vga_b} = lrgb;
        hsync = !(gx >= HS && gx < HS + HSL);
        vsync = !(gy >= VS && gy < VS + VSL);
        @(posedge clk);
        lx = gx;
        ly = gy;
        gx++;
        if (gx == ((gy == short_y) ? HT - 1 : HT)) begin
            gx = 0;
            if (gy == short_y) short_y = -1;
            gy++;
            if (gy == (short_frame ? VT - 1 : VT)) begin
                gy = 0;
                short_frame = 1'b0;
            end
        end
        #1;
    endtask

    task automatic run_until(input int x, input int y);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(lx == x && ly == y) && n < 2 * HT * VT);
        if (!(lx == x && ly == y)) begin
            tests++;
            fails++;
            $error("FAIL run_until: at %0d,%0d expected %0d,%0d",
                   lx, ly, x, y);
        end
    endtask

    // Three vsync falls: enter ACQUIRE, then two clean frames.
    task automatic relock(input string tag);
        for (int k = 0; k < 3; k++) begin
            run_until(0, VS);
            chk({tag, " unlocked at vs fall"}, locked, 0);
        end
        step();
        chk({tag, " locked"}, locked, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " hpos"}, hpos, 0);
        chk({tag, " vpos"}, vpos, 0);
        chk({tag, " pix_rgb"}, pix_rgb, 0);
        chk({tag, " locked"}, locked, 0);
        chk({tag, " pos_valid"}, pos_valid, 0);
        chk({tag, " probe_rgb"}, probe_rgb, 0);
        chk({tag, " probe_valid"}, probe_valid, 0);
        chk({tag, " line_err"}, line_err, 0);
        chk({tag, " frame_err"}, frame_err, 0);
        chk({tag, " frame_done"}, frame_done, 0);
    endtask

    initial begin
        reset = 1'b0;
        hsync = 1'b1;
        vsync = 1'b1;
        {vga_r, vga_g, vga_b} = 12'hABC;
        probe_x = 11'd700;
        probe_y = 11'd10;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b1;

        relock("lock1");
        chk("lock1 line_err count", le_cnt, 0);
        chk("lock1 frame_err count", fe_cnt, 0);
        chk("far probe no capture", probe_rgb, 0);

        mode = 1;
        run_until(31, 3);
        chk("lat hpos 31", hpos, 31);
        chk("lat vpos 3", vpos, 3);
        chk("lat pix 31,3", pix_rgb, lrgb);
        chk("pos_valid at hpos 31", pos_valid, 1);
        step();
        chk("lat hpos 32", hpos, HV);
        chk("lat pix 32,3", pix_rgb, lrgb);
        chk("pos_valid at hpos 32", pos_valid, 0);
        run_until(5, 11);
        chk("lat vpos 11", vpos, 11);
        chk("pos_valid at vpos 11", pos_valid, 1);
        run_until(5, 12);
        chk("lat vpos 12", vpos, VV);
        chk("pos_valid at vpos 12", pos_valid, 0);

        mode = 0;
        probe_x = 11'(PX);
        probe_y = 11'(PY);
        run_until(PX, PY);
        chk("white pixel", pix_rgb, 12'hFFF);
        chk("probe_valid before capture", probe_valid, 0);
        step();
        chk("probe_valid pulse", probe_valid, 1);
        chk("probe_rgb white", probe_rgb, 12'hFFF);
        step();
        chk("probe_valid one cycle", probe_valid, 0);
        pv0 = pv_cnt;
        fd0 = fd_cnt;
        run_until(PX + 2, PY);
        chk("probe pulses per frame", pv_cnt - pv0, 1);
        chk("frame_done per frame", fd_cnt - fd0, 1);
        probe_x = 11'(HV + 2);
        pv0 = pv_cnt;
        run_until(PX + 2, PY);
        chk("outside probe pulses", pv_cnt - pv0, 0);
        chk("probe_rgb held", probe_rgb, 12'hFFF);

        le0 = le_cnt;
        fe0 = fe_cnt;
        short_y = 3;
        run_until(HS, 4);
        chk("short line line_err", line_err, 1);
        chk("short line still locked", locked, 1);
        step();
        chk("short line err one cycle", line_err, 0);
        chk("short line unlock", locked, 0);
        relock("lock2");
        chk("short line err count", le_cnt - le0, 1);
        chk("short line frame_err count", fe_cnt - fe0, 0);

        le0 = le_cnt;
        fe0 = fe_cnt;
        short_frame = 1'b1;
        run_until(0, VS);
        chk("short frame frame_err", frame_err, 1);
        chk("short frame still locked", locked, 1);
        step();
        chk("short frame err one cycle", frame_err, 0);
        chk("short frame unlock", locked, 0);
        relock("lock3");
        chk("short frame err count", fe_cnt - fe0, 1);
        chk("short frame line_err count", le_cnt - le0, 0);

        run_until(20, 7);
        chk("pre-reset pos_valid", pos_valid, 1);
        chk("pre-reset pix", pix_rgb, 12'h137);
        le0 = le_cnt;
        fe0 = fe_cnt;
        reset = 1'b0;
        #1;
        chk_zero("mid reset");
        repeat (3) step();
        chk("reset held hpos", hpos, 0);
        chk("reset held locked", locked, 0);
        reset = 1'b1;
        relock("lock4");
        chk("after reset line_err count", le_cnt - le0, 0);
        chk("after reset frame_err count", fe_cnt - fe0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_rx_monitor.md
VGA_RX_MONITOR -- requirements
Module: vga_rx_monitor

Interface
REQ-001 H_TOTAL, 800, pixel clocks per line.
REQ-002 H_SYNC_START, 656, horizontal position loaded at hsync falling edge.
REQ-003 V_TOTAL, 525, lines per frame.
REQ-004 V_SYNC_START, 490, vertical position loaded at vsync falling edge.
REQ-005 H_VISIBLE / V_VISIBLE, 640 / 480, active area size.
REQ-006 clk  in  1  25 MHz pixel clock; the only clock.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 hsync, vsync  in  1 each  active-low syncs; synchronous to clk, no synchronizers.
REQ-009 vga_r, vga_g, vga_b  in  4 each  pixel colour, synchronous to clk.
REQ-010 probe_x, probe_y  in  11 each  coordinate to capture.
REQ-011 hpos, vpos  out  11 each  recovered coordinate of the pixel on pix_rgb.
REQ-012 pix_rgb  out  12  registered {r,g,b}.
REQ-013 pos_valid  out  1  locked and pixel inside the active area.
REQ-014 locked  out  1  timing lock indicator.
REQ-015 probe_rgb  out  12  colour captured at the probe coordinate; probe_valid  out  1  one-cycle pulse on capture.
REQ-016 line_err, frame_err  out  1 each  one-cycle error pulses.
REQ-017 frame_done  out  1  one-cycle pulse at each vsync falling edge while locked.

Function
REQ-018 Edge detection: registered previous hsync/vsync; falling edge = prev 1, current 0.
REQ-019 hcnt increments each cycle, wraps H_TOTAL-1 -> 0; on hsync fall it loads H_SYNC_START (takes priority over increment).
REQ-020 vcnt increments on hcnt wrap, wraps V_TOTAL-1 -> 0; on vsync fall it loads V_SYNC_START (priority over increment).
REQ-021 Simultaneous hsync and vsync fall: both loads apply in the same cycle.
REQ-022 Latency: inputs sampled at edge N appear on pix_rgb/hpos/vpos/pos_valid after edge N+1, exactly 1 cycle.
REQ-023 Line meter counts cycles between consecutive hsync falls, saturating at 2047; line_err pulses when a period != H_TOTAL; the first edge after reset is not checked.
REQ-024 Frame meter counts hsync falls between consecutive vsync falls, saturating at 2047; frame_err pulses when the count != V_TOTAL; the first vsync fall after reset is not checked.
REQ-025 FSM states: SEARCH, ACQUIRE, LOCKED.
REQ-026 SEARCH -> ACQUIRE on the first vsync fall.
REQ-027 ACQUIRE -> LOCKED after 2 consecutive error-free frames.
REQ-028 Any line_err or frame_err in ACQUIRE or LOCKED -> SEARCH, and the good-frame count clears.
REQ-029 locked = (state == LOCKED), registered; it drops the cycle after the error pulse.
REQ-030 pos_valid = locked && hpos < H_VISIBLE && vpos < V_VISIBLE.
REQ-031 Probe capture: when pos_valid and hpos == probe_x and vpos == probe_y, probe_rgb loads pix_rgb and probe_valid pulses 1 cycle later.
REQ-032 probe_rgb holds its value between captures.
REQ-033 A probe coordinate outside the active area never captures.
REQ-034 Sync pulses shorter than 1 cycle are not detectable; every low sample counts as a level.

Reset
REQ-035 On reset low, all outputs go to 0 asynchronously.
REQ-036 On reset low, state = SEARCH, hcnt = vcnt = 0, prev syncs = 1, meters cleared with the first-edge flags set.
REQ-037 Reset mid-frame discards lock; after release the block requires 1 vsync fall plus 2 good frames to relock.

Structure
REQ-038 Package vga_timing_pkg holds all timing constants and the state enum; the display generator shares the same constants.
REQ-039 One sub-module, vga_period_meter (edge-in, count-enable, expected value, err pulse, saturating counter), is instantiated twice: once for lines, once for frames.

Verification
REQ-040 Ideal 640x480 stream from the display generator, 3 frames -> locked rises 1 cycle after the 3rd vsync fall; no err pulses.
REQ-041 Locked; one line shortened to 799 clocks -> line_err pulse at the next hsync fall, then locked = 0 the next cycle; relock after 2 clean frames.
REQ-042 Frame with 524 lines -> frame_err at the vsync fall; state returns to SEARCH.
REQ-043 White pixel at (160,140) on a 0x137 background, probe = (160,140) -> probe_rgb = 0xFFF, probe_valid once per frame; probe = (700,10) -> no pulse.
REQ-044 Check pixel latency and coordinates while locked -> pix_rgb/hpos/vpos equal the input sampled 1 cycle earlier; pos_valid = 0 at hpos = 640.
REQ-045 Assert reset for 3 cycles mid-line while locked -> all outputs 0 immediately; relock after 1 vsync fall plus 2 clean frames.
